video_timing_gen: RTL and testbench

Parametrised video timing generator and stream-to-raster converter feeding the `video_if` master side (`CLK`/`HS`/`VS`/`BLANK`/`RGB`) of the SoCFPGA video controller. It replaces the fixed-geometry controller:
- Porches, sync widths and colour depth are parameters.
- Pixels arrive on a valid/ready stream with a start-of-frame marker.
- The block locks the stream to the raster and recovers from misalignment.
- Underflow and sync errors are flagged.

---
 rtl/video_timing_gen_if.sv | 27 ++
 rtl/video_timing_gen.sv | 265 ++++++++++++++++++++++++++
 tb/tb_video_timing_gen.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_timing_gen_if.sv
// ---------------------------------------------------------------------------
// video_if : raster video bus between the timing generator and the SoCFPGA
//            video controller.
//
// Signals
//   CLK    pixel clock forwarded by the master
//   HS     horizontal sync, active low
//   VS     vertical sync, active low
//   BLANK  1 while the pixel on RGB is in the active area
//   RGB    pixel {R,G,B}, CW bits per channel, 0 outside the active area
//
// Modports
//   master : drives every signal (timing generator side)
//   slave  : samples every signal (controller / monitor side)
// ---------------------------------------------------------------------------
interface video_if #(
  parameter int CW = 8
);
  logic            CLK;
  logic            HS;
  logic            VS;
  logic            BLANK;
  logic [3*CW-1:0] RGB;

  modport master (output CLK, HS, VS, BLANK, RGB);
  modport slave  (input  CLK, HS, VS, BLANK, RGB);
endinterface

// File: rtl/video_timing_gen.sv
// ---------------------------------------------------------------------------
// video_timing_gen : parametrised raster timing generator that locks a
//                    valid/ready pixel stream (with start-of-frame marker)
//                    onto the raster and drives the video_if master side.
//
// Ports
//   pixel_clk    in   pixel clock, forwarded as video_ifm.CLK
//   pixel_rst_n  in   asynchronous active-low reset
//   pix_data     in   pixel {R,G,B}, 3*CW bits
//   pix_valid    in   stream beat valid
//   pix_sof      in   beat is pixel (0,0) of a frame
//   pix_ready    out  beat accepted when pix_valid && pix_ready
//   pat_sel      in   test pattern select (only with VIDEO_PATTERN_EN)
//   video_ifm    video_if master: HS, VS (active low), BLANK, RGB
//   underflow    out  sticky: active pixel had no beat while locked
//   sync_err     out  sticky: accepted beat's SOF disagreed with raster
//   frame_cnt    out  completed frames, wraps
//
// Optional feature macro: VIDEO_PATTERN_EN adds the pat_sel input and the
// built-in colour-bar / checkerboard / white patterns.
//
// Stream lock state machine
//   state      | meaning
//   ST_RESYNC  | drain non-SOF beats, hold the first SOF beat
//   ST_WAIT    | SOF beat held, waiting for raster position (0,0)
//   ST_LOCKED  | one beat consumed per active pixel, SOF checked
//
// All video outputs are registered with a single cycle of latency.
// ---------------------------------------------------------------------------
module video_timing_gen #(
  parameter int HDISP  = 800,
  parameter int VDISP  = 480,
  parameter int HFP    = 40,
  parameter int HPULSE = 48,
  parameter int HBP    = 40,
  parameter int VFP    = 13,
  parameter int VPULSE = 3,
  parameter int VBP    = 29,
  parameter int CW     = 8
) (
  input  logic            pixel_clk,
  input  logic            pixel_rst_n,
  input  logic [3*CW-1:0] pix_data,
  input  logic            pix_valid,
  input  logic            pix_sof,
  output logic            pix_ready,
`ifdef VIDEO_PATTERN_EN
  input  logic [1:0]      pat_sel,
`endif
  video_if.master         video_ifm,
  output logic            underflow,
  output logic            sync_err,
  output logic [15:0]     frame_cnt
);

  localparam int HTOTAL = HDISP + HFP + HPULSE + HBP;
  localparam int VTOTAL = VDISP + VFP + VPULSE + VBP;
  localparam int HW     = $clog2(HTOTAL);
  localparam int VW     = $clog2(VTOTAL);

  localparam logic [HW-1:0] H_MAX = HW'(HTOTAL - 1);
  localparam logic [VW-1:0] V_MAX = VW'(VTOTAL - 1);

  // Region bounds kept at 32 bits so a zero back porch cannot overflow them.
  localparam logic [31:0] H_ACT_END  = 32'(HDISP);
  localparam logic [31:0] H_SYNC_BEG = 32'(HDISP + HFP);
  localparam logic [31:0] H_SYNC_END = 32'(HDISP + HFP + HPULSE);
  localparam logic [31:0] V_ACT_END  = 32'(VDISP);
  localparam logic [31:0] V_SYNC_BEG = 32'(VDISP + VFP);
  localparam logic [31:0] V_SYNC_END = 32'(VDISP + VFP + VPULSE);

  typedef enum logic [1:0] {
    ST_RESYNC = 2'd0,
    ST_WAIT   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [HW-1:0]    h_q, h_d;
  logic [VW-1:0]    v_q, v_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic             blank_q, blank_d;
  logic [3*CW-1:0]  rgb_q, rgb_d;
  logic             underflow_q, underflow_d;
  logic             sync_err_q, sync_err_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;

  logic [31:0]      h_ext, v_ext;
  logic             h_last, v_last;
  logic             origin, active;
  logic             chk_cyc;
  logic             accept;
  logic             show_beat;
  logic             sof_err_ev;
  logic             under_ev;
  logic             pat_on;

  assign h_ext  = 32'(h_q);
  assign v_ext  = 32'(v_q);
  assign h_last = (h_q == H_MAX);
  assign v_last = (v_q == V_MAX);
  assign origin = (h_q == '0) && (v_q == '0);
  assign active = (h_ext < H_ACT_END) && (v_ext < V_ACT_END);

  // -------------------------------------------------------------------------
  // Optional test patterns
  // -------------------------------------------------------------------------
`ifdef VIDEO_PATTERN_EN
  localparam logic [31:0] BAR_W = (HDISP / 8 > 0) ? 32'(HDISP / 8) : 32'd1;

  logic [1:0]      pat_q;
  logic [31:0]     bar_raw;
  logic [2:0]      bar_idx;
  logic [2:0]      pat_bits;
  logic [3*CW-1:0] pat_rgb;

  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) pat_q <= 2'd0;
    else              pat_q <= pat_sel;
  end

  // Pixels beyond the eighth full bar repeat the last (black) bar.
  always_comb begin
    bar_raw  = h_ext / BAR_W;
    bar_idx  = (bar_raw > 32'd7) ? 3'd7 : bar_raw[2:0];
    pat_bits = 3'b000;
    case (pat_q)
      2'd1: begin
        case (bar_idx)
          3'd0:    pat_bits = 3'b111;
          3'd1:    pat_bits = 3'b110;
          3'd2:    pat_bits = 3'b011;
          3'd3:    pat_bits = 3'b010;
          3'd4:    pat_bits = 3'b101;
          3'd5:    pat_bits = 3'b100;
          3'd6:    pat_bits = 3'b001;
          default: pat_bits = 3'b000;
        endcase
      end
      2'd2:    pat_bits = (h_ext[4] ^ v_ext[4]) ? 3'b000 : 3'b111;
      2'd3:    pat_bits = 3'b111;
      default: pat_bits = 3'b000;
    endcase
  end

  assign pat_rgb = {{CW{pat_bits[2]}}, {CW{pat_bits[1]}}, {CW{pat_bits[0]}}};
  assign pat_on  = (pat_q != 2'd0);
`else
  assign pat_on  = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Raster counters
  // -------------------------------------------------------------------------
  always_comb begin
    h_d         = h_last ? '0 : h_q + 1'b1;
    v_d         = v_q;
    frame_cnt_d = frame_cnt_q;
    if (h_last) begin
      v_d = v_last ? '0 : v_q + 1'b1;
      if (v_last) frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  // -------------------------------------------------------------------------
  // Stream lock state machine
  // -------------------------------------------------------------------------
  // chk_cyc marks cycles in which an accepted beat is displayed and its SOF
  // flag is checked against the raster. That includes the WAIT cycle at
  // (0,0), where the held SOF beat is consumed as the first locked pixel.
  always_comb begin
    state_d    = state_q;
    pix_ready  = 1'b0;
    chk_cyc    = 1'b0;
    case (state_q)
      ST_RESYNC: begin
        pix_ready = !(pix_valid && pix_sof);
        if (pix_valid && pix_sof) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        pix_ready = origin;
        chk_cyc   = origin;
        if (origin) state_d = ST_LOCKED;
      end
      ST_LOCKED: begin
        pix_ready = active;
        chk_cyc   = 1'b1;
      end
      default: state_d = ST_RESYNC;
    endcase

    accept     = pix_valid && pix_ready;
    show_beat  = chk_cyc && active && accept;
    sof_err_ev = chk_cyc && accept && (pix_sof != origin);
    // A missing beat is skipped, not retried; a later SOF check catches the
    // resulting slip.
    under_ev   = chk_cyc && active && !pix_valid;

    if (sof_err_ev) state_d = ST_RESYNC;

    // Patterns own the raster: stream is stalled and flags are frozen.
    if (pat_on) begin
      pix_ready  = 1'b0;
      state_d    = ST_RESYNC;
      accept     = 1'b0;
      show_beat  = 1'b0;
      sof_err_ev = 1'b0;
      under_ev   = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Registered video outputs and flags
  // -------------------------------------------------------------------------
  always_comb begin
    hs_d        = !((h_ext >= H_SYNC_BEG) && (h_ext < H_SYNC_END));
    vs_d        = !((v_ext >= V_SYNC_BEG) && (v_ext < V_SYNC_END));
    blank_d     = active;
    rgb_d       = '0;
    if (active && show_beat) rgb_d = pix_data;
`ifdef VIDEO_PATTERN_EN
    if (active && pat_on) rgb_d = pat_rgb;
`endif
    underflow_d = underflow_q | under_ev;
    sync_err_d  = sync_err_q | sof_err_ev;
  end

  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      state_q     <= ST_RESYNC;
      h_q         <= '0;
      v_q         <= '0;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      blank_q     <= 1'b0;
      rgb_q       <= '0;
      underflow_q <= 1'b0;
      sync_err_q  <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      v_q         <= v_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      blank_q     <= blank_d;
      rgb_q       <= rgb_d;
      underflow_q <= underflow_d;
      sync_err_q  <= sync_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign video_ifm.CLK   = pixel_clk;
  assign video_ifm.HS    = hs_q;
  assign video_ifm.VS    = vs_q;
  assign video_ifm.BLANK = blank_q;
  assign video_ifm.RGB   = rgb_q;

  assign underflow = underflow_q;
  assign sync_err  = sync_err_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_video_timing_gen : self-checking bench for video_timing_gen using the
// small 16x8 raster. A randomised stream source feeds the DUT; a reference
// model derives raster position from elapsed cycles and applies the stream
// locking rules to predict every output.
// ---------------------------------------------------------------------------
module tb_video_timing_gen;

  localparam int HD = 8, VD = 4, HFP = 2, HP = 3, HBP = 3, VFP = 1, VP = 2, VBP = 1, CW = 8;
  localparam int HT = HD + HFP + HP + HBP;
  localparam int VT = VD + VFP + VP + VBP;
  localparam int FR = HT * VT;

  localparam int M_HUNT = 10, M_ARMED = 20, M_RUN = 30;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [3*CW-1:0] pix_data;
  logic            pix_valid;
  logic            pix_sof;
  logic            pix_ready;
  logic            underflow;
  logic            sync_err;
  logic [15:0]     frame_cnt;
`ifdef VIDEO_PATTERN_EN
  logic [1:0]      pat_sel = 2'd0;
`endif

  video_if #(.CW(CW)) vif ();

  video_timing_gen #(
    .HDISP(HD), .VDISP(VD), .HFP(HFP), .HPULSE(HP), .HBP(HBP),
    .VFP(VFP), .VPULSE(VP), .VBP(VBP), .CW(CW)
  ) dut (
    .pixel_clk   (clk),
    .pixel_rst_n (rst_n),
    .pix_data    (pix_data),
    .pix_valid   (pix_valid),
    .pix_sof     (pix_sof),
    .pix_ready   (pix_ready),
`ifdef VIDEO_PATTERN_EN
    .pat_sel     (pat_sel),
`endif
    .video_ifm   (vif),
    .underflow   (underflow),
    .sync_err    (sync_err),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  int          m_t;
  int          m_st;
  bit          m_und, m_err;
  logic [15:0] m_frames;
  bit          e_hs, e_vs, e_blank;
  logic [23:0] e_rgb;

  // Stream source
  int          src_idx;
  bit          src_v;
  int          gap_pct;
  bit          drop_now;
  logic [15:0] salt;

  function automatic logic [23:0] beat_val(input int idx);
    return {salt ^ 16'(idx * 37), 8'(idx)};
  endfunction

  function automatic int cur_h();
    return m_t % HT;
  endfunction

  function automatic int cur_v();
    return (m_t / HT) % VT;
  endfunction

  task automatic model_init();
    m_t      = 0;
    m_st     = M_HUNT;
    m_und    = 1'b0;
    m_err    = 1'b0;
    m_frames = 16'd0;
  endtask

  task automatic check_outputs();
    chk("HS",        32'(vif.HS),    32'(e_hs));
    chk("VS",        32'(vif.VS),    32'(e_vs));
    chk("BLANK",     32'(vif.BLANK), 32'(e_blank));
    chk("RGB",       32'(vif.RGB),   32'(e_rgb));
    chk("underflow", 32'(underflow), 32'(m_und));
    chk("sync_err",  32'(sync_err),  32'(m_err));
    chk("frame_cnt", 32'(frame_cnt), 32'(m_frames));
  endtask

  // Drive this cycle's beat, then predict ready and the next registered outputs.
  task automatic drive_and_step();
    int h, v;
    bit org, act, rdy, chkc, show, err, und;
    if (!src_v) src_v = ($urandom_range(99) < gap_pct);
    pix_valid = src_v && !drop_now;
    pix_sof   = (src_idx % 32) == 0;
    pix_data  = beat_val(src_idx);
    #1;
    h   = m_t % HT;
    v   = (m_t / HT) % VT;
    org = (h == 0) && (v == 0);
    act = (h < HD) && (v < VD);
    if (m_st == M_HUNT) begin
      rdy = !(pix_valid && pix_sof); chkc = 1'b0;
    end else if (m_st == M_ARMED) begin
      rdy = org; chkc = org;
    end else begin
      rdy = act; chkc = 1'b1;
    end
    chk("pix_ready", 32'(pix_ready), 32'(rdy));
    show = chkc && act && pix_valid && rdy;
    err  = chkc && pix_valid && rdy && (pix_sof != org);
    und  = chkc && act && !pix_valid;
    if (m_st == M_HUNT && pix_valid && pix_sof) m_st = M_ARMED;
    else if (m_st == M_ARMED && org)            m_st = M_RUN;
    if (err) m_st = M_HUNT;
    e_hs    = !(h >= HD + HFP && h < HD + HFP + HP);
    e_vs    = !(v >= VD + VFP && v < VD + VFP + VP);
    e_blank = act;
    e_rgb   = show ? pix_data : 24'h0;
    if (und) m_und = 1'b1;
    if (err) m_err = 1'b1;
    if (h == HT - 1 && v == VT - 1) m_frames = m_frames + 16'd1;
    m_t++;
    if (pix_valid && rdy) begin
      src_idx++;
      src_v = 1'b0;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    drive_and_step();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_HS"},    32'(vif.HS),    32'd1);
    chk({tag, "_VS"},    32'(vif.VS),    32'd1);
    chk({tag, "_BLANK"}, 32'(vif.BLANK), 32'd0);
    chk({tag, "_RGB"},   32'(vif.RGB),   32'd0);
    chk({tag, "_und"},   32'(underflow), 32'd0);
    chk({tag, "_serr"},  32'(sync_err),  32'd0);
    chk({tag, "_frame"}, 32'(frame_cnt), 32'd0);
    chk({tag, "_ready"}, 32'(pix_ready), 32'd1);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    model_init();
    drive_and_step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit dropped;
    bit found;
    salt      = 16'($urandom);
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    pix_data  = '0;
    src_v     = 1'b0;
    src_idx   = 0;
    gap_pct   = 0;
    drop_now  = 1'b0;
    rst_n     = 1'b0;
    model_init();

    // Reset state, including the combinational RESYNC ready rule.
    repeat (2) @(negedge clk);
    #1;
    check_reset_values("rst");
    chk("vid_clk_low", 32'(vif.CLK), 32'd0);
    pix_valid = 1'b1;
    pix_sof   = 1'b1;
    #1;
    chk("rst_ready_sof", 32'(pix_ready), 32'd0);
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    release_reset();

    // No stream: pure timing for one frame.
    repeat (FR) cycle();
    chk("frame_after_128", 32'(frame_cnt), 32'd1);

    // Always-valid stream: lock in the first frame, clean display after.
    gap_pct = 100;
    repeat (3 * FR) cycle();
    chk("locked_und", 32'(underflow), 32'd0);
    chk("locked_serr", 32'(sync_err), 32'd0);

    // Drop one beat at (3,1) of a locked frame.
    dropped = 1'b0;
    for (int i = 0; i < 2 * FR && !dropped; i++) begin
      drop_now = (m_st == M_RUN) && (cur_h() == 3) && (cur_v() == 1);
      if (drop_now) dropped = 1'b1;
      cycle();
      drop_now = 1'b0;
    end
    chk("drop_seen", 32'(dropped), 32'd1);
    repeat (FR) cycle();
    chk("drop_und", 32'(underflow), 32'd1);
    repeat (3 * FR) cycle();
    chk("drop_serr", 32'(sync_err), 32'd1);

    // Random gaps.
    gap_pct = 85;
    repeat (10 * FR) cycle();

    // Asynchronous reset mid-frame at (5,2), held for 3 cycles.
    gap_pct = 100;
    found   = 1'b0;
    for (int i = 0; i < FR && !found; i++) begin
      if (cur_h() == 5 && cur_v() == 2) found = 1'b1;
      else cycle();
    end
    chk("mid_pos_found", 32'(found), 32'd1);
    @(negedge clk);
    check_outputs();
    rst_n     = 1'b0;
    pix_valid = 1'b0;
    #1;
    check_reset_values("mid_rst");
    repeat (2) @(negedge clk);
    release_reset();
    repeat (4 * FR) cycle();
    chk("relock_und", 32'(underflow), 32'd0);
    chk("relock_serr", 32'(sync_err), 32'd0);

    // frame_cnt wrap: preset to 0xFFFF mid-frame, next frame end gives 0.
    repeat (5) cycle();
    @(negedge clk);
    check_outputs();
    force dut.frame_cnt_q = 16'hFFFF;
    #1;
    release dut.frame_cnt_q;
    m_frames = 16'hFFFF;
    drive_and_step();
    repeat (FR) cycle();
    chk("frame_wrap", 32'(frame_cnt), 32'd0);

`ifdef VIDEO_PATTERN_EN
    begin
      logic [23:0] bars [8];
      bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
      @(negedge clk);
      rst_n     = 1'b0;
      pat_sel   = 2'd1;
      pix_valid = 1'b1;
      pix_sof   = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 2 * FR; k++) begin
        @(negedge clk);
        #1;
        chk("pat_ready", 32'(pix_ready), 32'd0);
        if (k - 1 >= FR && k - 1 < FR + HD)
          chk("pat_bar", 32'(vif.RGB), 32'(bars[k - 1 - FR]));
      end
      chk("pat_und", 32'(underflow), 32'd0);
      chk("pat_serr", 32'(sync_err), 32'd0);
      pat_sel   = 2'd0;
      pix_valid = 1'b0;
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
